// File: rtl/time_tag_sequencer_if.sv
// time_tag_sequencer_if: valid/ready tag stream from the sequencer to the readout logic.
//   tag_data  captured timestamp       tag_src   requester index
//   tag_sec   second count at capture  tag_valid source holds a tag
//   tag_ready sink accepts the tag
//   master = tag source (sequencer), slave = tag sink (readout)
interface time_tag_sequencer_if #(
  parameter int CNT_W = 27,
  parameter int SRC_W = 2
);
  logic [CNT_W-1:0] tag_data;
  logic [SRC_W-1:0] tag_src;
  logic [15:0] tag_sec;
  logic tag_valid;
  logic tag_ready;
  modport master(output tag_data, tag_src, tag_sec, tag_valid, input tag_ready);
  modport slave(input tag_data, tag_src, tag_sec, tag_valid, output tag_ready);
endinterface

// File: rtl/time_tag_sequencer.sv
// time_tag_sequencer: GPS PPS sequencing of the time-tag counter plus round-robin timestamp capture.
//   clk, res          clock, synchronous active-high reset
//   pps               asynchronous GPS PPS
//   cnt_in, cnt_load  live counter value / load-to-1 pulse to the counter
//   req, tag          per-source capture requests / tag stream (master side)
//   pps_period(_valid) clocks in the last full second / update pulse
//   pps_lost          no PPS for PPS_TIMEOUT clocks
//   req_drop, drop_clr sticky lost-request flags / clear
// Define TIME_TAG_SEC_STAMP_EN to build the second counter and tag_sec path; otherwise tag_sec is 0.
module time_tag_sequencer #(
  parameter int CNT_W = 27,
  parameter int N_REQ = 4,
  parameter int SRC_W = 2,
  parameter int PPS_SYNC = 2,
  parameter int PPS_TIMEOUT = 125000000
) (
  input  logic clk,
  input  logic res,
  input  logic pps,
  input  logic [CNT_W-1:0] cnt_in,
  output logic cnt_load,
  input  logic [N_REQ-1:0] req,
  time_tag_sequencer_if.master tag,
  output logic [CNT_W-1:0] pps_period,
  output logic pps_period_valid,
  output logic pps_lost,
  output logic [N_REQ-1:0] req_drop,
  input  logic drop_clr
);
  logic [PPS_SYNC-1:0] pps_sync;
  logic pps_hist, first_pps, found, fire;
  logic [N_REQ-1:0] pending, cap, free;
  logic [SRC_W-1:0] ptr, gnt, idx;
  logic [CNT_W-1:0] slot_ts [N_REQ];
  // Scan downward so the pending source closest to ptr is the one left in gnt.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(ptr) + k) % N_REQ);
      gnt = pending[idx] ? idx : gnt;
    end
  end
  assign found = |pending;
  assign fire = found & (~tag.tag_valid | tag.tag_ready);
  assign free = fire ? N_REQ'(1) << gnt : '0;
  // A slot freed by this cycle's grant can take a new request without a drop.
  assign cap = req & (~pending | free);
  // Sync flops and edge history reset high so a PPS held high through reset is not an edge.
  always_ff @(posedge clk) begin
    if (res) begin
      pps_sync <= '1;
      pps_hist <= 1'b1;
      first_pps <= 1'b0;
      cnt_load <= 1'b0;
      pps_period <= '0;
      pps_period_valid <= 1'b0;
      pps_lost <= 1'b0;
      pending <= '0;
      req_drop <= '0;
      ptr <= '0;
      tag.tag_data <= '0;
      tag.tag_src <= '0;
      tag.tag_valid <= 1'b0;
    end else begin
      pps_sync <= {pps_sync[PPS_SYNC-2:0], pps};
      pps_hist <= pps_sync[PPS_SYNC-1];
      cnt_load <= pps_sync[PPS_SYNC-1] & ~pps_hist;
      pps_period_valid <= cnt_load & first_pps;
      if (cnt_load) first_pps <= 1'b1;
      if (cnt_load & first_pps) pps_period <= cnt_in;
      pps_lost <= cnt_load ? 1'b0 : pps_lost | (cnt_in == CNT_W'(PPS_TIMEOUT));
      pending <= (pending & ~free) | cap;
      req_drop <= (req_drop & ~{N_REQ{drop_clr}}) | (req & pending & ~free);
      if (fire) begin
        ptr <= (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
        tag.tag_data <= slot_ts[gnt];
        tag.tag_src <= gnt;
        tag.tag_valid <= 1'b1;
      end else if (tag.tag_ready) begin
        tag.tag_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++)
      if (cap[i]) slot_ts[i] <= cnt_in;
  end
`ifdef TIME_TAG_SEC_STAMP_EN
  logic [15:0] sec_cnt;
  logic [15:0] slot_sec [N_REQ];
  // Captures read sec_cnt before a coincident increment, so they keep the old second.
  always_ff @(posedge clk) begin
    if (res) begin
      sec_cnt <= '0;
      tag.tag_sec <= '0;
    end else begin
      if (cnt_load) sec_cnt <= sec_cnt + 16'd1;
      if (fire) tag.tag_sec <= slot_sec[gnt];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++)
      if (cap[i]) slot_sec[i] <= sec_cnt;
  end
`else
  assign tag.tag_sec = '0;
`endif
endmodule

// File: tb/tb_time_tag_sequencer.sv
// tb_time_tag_sequencer: directed self-checking bench for time_tag_sequencer.
module tb_time_tag_sequencer;
  localparam int CNT_W = 27, N_REQ = 4, SRC_W = 2, TMO = 3000;
  logic clk = 0, res = 1, pps = 1, drop_clr = 0, cnt_load, pps_period_valid, pps_lost;
  logic [CNT_W-1:0] cnt_in = '0, pps_period;
  logic [N_REQ-1:0] req = '0, req_drop;
  logic load_prev = 0;
  int n_cmp = 0, n_bad = 0, load_hi = 0, load_rise = 0, pv_cnt = 0, vcnt = 0;
  logic [CNT_W-1:0] cap_val;
  time_tag_sequencer_if #(.CNT_W(CNT_W), .SRC_W(SRC_W)) tag_if ();
  time_tag_sequencer #(.CNT_W(CNT_W), .N_REQ(N_REQ), .SRC_W(SRC_W), .PPS_SYNC(2), .PPS_TIMEOUT(TMO)) dut (
    .clk(clk), .res(res), .pps(pps), .cnt_in(cnt_in), .cnt_load(cnt_load), .req(req), .tag(tag_if),
    .pps_period(pps_period), .pps_period_valid(pps_period_valid), .pps_lost(pps_lost),
    .req_drop(req_drop), .drop_clr(drop_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // One clock: sample #1 after the edge, then advance the modelled counter (reads 1 after a load cycle).
  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_load) load_hi++;
    if (cnt_load && !load_prev) load_rise++;
    if (pps_period_valid) pv_cnt++;
    cnt_in = load_prev ? CNT_W'(1) : cnt_in + 1'b1;
    load_prev = cnt_load;
  endtask
  task automatic wait_load(input string tag);
    int n = 0;
    while (!cnt_load && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(cnt_load), 1);
  endtask
  initial begin
    tag_if.tag_ready = 0;
    repeat (3) tick();
    check("rst_valid", 32'(tag_if.tag_valid), 0);
    check("rst_data", 32'(tag_if.tag_data), 0);
    check("rst_period", 32'(pps_period), 0);
    check("rst_lost", 32'(pps_lost), 0);
    check("rst_drop", 32'(req_drop), 0);
    res = 0;
    repeat (8) tick();
    check("no_load_pps_high", 32'(load_hi), 0);
    check("no_pv_pps_high", 32'(pv_cnt), 0);
    pps = 0;
    repeat (5) tick();
    pps = 1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (k == 10) pps = 0;
    end
    check("load_first", 32'(load_hi), 1);
    check("pv_first", 32'(pv_cnt), 0);
    pps = 1;
    repeat (10) tick();
    pps = 0;
    check("load_cycles", 32'(load_hi), 2);
    check("load_pulses", 32'(load_rise), 2);
    check("pv_second", 32'(pv_cnt), 1);
    check("period", 32'(pps_period), 1000);
    tag_if.tag_ready = 1;
    cap_val = cnt_in;
    req = 4'b1111;
    tick();
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_valid", 32'(tag_if.tag_valid), 1);
      check("rr_src", 32'(tag_if.tag_src), i);
      check("rr_data", 32'(tag_if.tag_data), 32'(cap_val));
`ifdef TIME_TAG_SEC_STAMP_EN
      check("rr_sec", 32'(tag_if.tag_sec), 2);
`else
      check("rr_sec", 32'(tag_if.tag_sec), 0);
`endif
    end
    tick();
    check("rr_idle", 32'(tag_if.tag_valid), 0);
    tag_if.tag_ready = 0;
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    check("hold_src0", 32'(tag_if.tag_src), 0);
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    check("drop_set", 32'(req_drop), 32'b0010);
    check("hold_valid", 32'(tag_if.tag_valid), 1);
    check("hold_src", 32'(tag_if.tag_src), 0);
    tag_if.tag_ready = 1;
    tick();
    check("b2b_valid", 32'(tag_if.tag_valid), 1);
    check("b2b_src1", 32'(tag_if.tag_src), 1);
    tick();
    check("one_tag1", 32'(tag_if.tag_valid), 0);
    check("drop_sticky", 32'(req_drop), 32'b0010);
    drop_clr = 1;
    tick();
    drop_clr = 0;
    check("drop_clr", 32'(req_drop), 0);
    check("lost_pre", 32'(pps_lost), 0);
    for (int n = 0; n < 4000 && !pps_lost; n++) tick();
    check("lost_set", 32'(pps_lost), 1);
    check("lost_at", 32'(cnt_in), TMO + 1);
    pps = 1;
    wait_load("load_third");
    check("lost_in_load", 32'(pps_lost), 1);
    cnt_in = CNT_W'(999);
    req = 4'b0100;
    tick();
    req = '0;
    pps = 0;
    check("lost_clr", 32'(pps_lost), 0);
    check("period_999", 32'(pps_period), 999);
    check("pv_third", 32'(pps_period_valid), 1);
    tick();
    check("edge_valid", 32'(tag_if.tag_valid), 1);
    check("edge_src", 32'(tag_if.tag_src), 2);
    check("edge_data", 32'(tag_if.tag_data), 999);
`ifdef TIME_TAG_SEC_STAMP_EN
    check("edge_sec", 32'(tag_if.tag_sec), 2);
`else
    check("edge_sec", 32'(tag_if.tag_sec), 0);
`endif
    tick();
    tag_if.tag_ready = 0;
    req = 4'b0011;
    tick();
    req = '0;
    tick();
    check("mid_valid", 32'(tag_if.tag_valid), 1);
    res = 1;
    tick();
    res = 0;
    check("mid_rst", 32'(tag_if.tag_valid), 0);
    tag_if.tag_ready = 1;
    repeat (4) begin
      tick();
      if (tag_if.tag_valid) vcnt++;
    end
    check("mid_discard", 32'(vcnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
